// File: rtl/datamem_seq_if.sv
// Load/store request/response bundle for datamem_seq.
// master drives requests and init_start; slave is the memory.
interface datamem_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  localparam int LANES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_start;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, init_start,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, init_start,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/datamem_seq.sv
// Word-addressed data memory with byte-lane writes, one-cycle read latency
// and a sweep FSM that initialises every word after reset or on request.
module datamem_seq #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 65536,
  parameter logic [DATA_W-1:0] BOOT_WORD = 16'b0100010001000010,
  localparam int               LANES     = DATA_W / 8
) (
  input  logic          clk,
  input  logic          reset_n,
  datamem_seq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [DATA_W-1:0] sweep_word(input logic [AW-1:0] p);
    return (p == '0) ? BOOT_WORD : '0;
  endfunction

  // Response data is forced to zero whenever no response is pending.
  function automatic logic [DATA_W-1:0] rsp_word(input logic vld, input logic [DATA_W-1:0] d);
    return vld ? d : '0;
  endfunction

  state_t            state;
  logic [AW-1:0]     ptr;
  logic              ready_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     addr_p0;
  logic              acc_p0;
  logic              rd_p0;
  logic              wr_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  // Stage p0: request acceptance; address wraps modulo DEPTH.
  assign addr_p0 = bus.req_addr[AW-1:0];
  assign acc_p0  = bus.req_valid && ready_q;
  assign rd_p0   = acc_p0 && !bus.req_write;
  assign wr_p0   = acc_p0 && bus.req_write;

  if (ADDR_W > AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:AW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      ptr     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == AW'(DEPTH - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (bus.init_start) begin
            state   <= ST_INIT;
            ptr     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // The sweep and request writes never coincide: requests are refused in ST_INIT.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[ptr] <= sweep_word(ptr);
    end else if (wr_p0) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.req_be[i]) mem[addr_p0][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
    if (rd_p0) rdata_p1 <= mem[addr_p0];
  end

  // Stage p1: read response, killed asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= rd_p0;
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_rdata = rsp_word(vld_p1, rdata_p1);
endmodule
